// File: rtl/sa_load_compute_ctrl_if.sv
// Host / array bundle for the systolic-array load/compute sequencer.
// master = host/DMA + array side, slave = sequencer.
// The ABORT wire only exists when SA_CTRL_ABORT_EN is defined.
interface sa_load_compute_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 16,
  parameter int ROWS   = 8
);
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                      start;
  logic                      ld_valid;
  logic                      ld_ready;
  logic [DATA_W*LANES-1:0]   ld_data;
  logic                      sa_en;
  logic                      sa_rf_en;
  logic                      sa_write;
  logic [IDX_W-1:0]          sa_idx;
  logic [DATA_W*LANES-1:0]   sa_din;
  logic                      busy;
  logic                      done;
`ifdef SA_CTRL_ABORT_EN
  logic                      abort;

  modport master (
    output start, ld_valid, ld_data, abort,
    input  ld_ready, sa_en, sa_rf_en, sa_write, sa_idx, sa_din, busy, done
  );
  modport slave (
    input  start, ld_valid, ld_data, abort,
    output ld_ready, sa_en, sa_rf_en, sa_write, sa_idx, sa_din, busy, done
  );
`else
  modport master (
    output start, ld_valid, ld_data,
    input  ld_ready, sa_en, sa_rf_en, sa_write, sa_idx, sa_din, busy, done
  );
  modport slave (
    input  start, ld_valid, ld_data,
    output ld_ready, sa_en, sa_rf_en, sa_write, sa_idx, sa_din, busy, done
  );
`endif
endinterface

// File: rtl/sa_load_compute_ctrl.sv
// Load/compute sequencer for the 8x8 SystolicArray with register file.
// Per START: stream ROWS row-words from the host into the array RF, keep WRITE
// high through the RF pipeline flush, run the matmul for COMPUTE_CYC cycles,
// then pulse DONE. Every output is a register loaded from the next-state decode.
// Optional feature macro: SA_CTRL_ABORT_EN (adds the ABORT input).
module sa_load_compute_ctrl #(
  parameter int DATA_W      = 16,
  parameter int LANES       = 16,
  parameter int ROWS        = 8,
  parameter int FLUSH_CYC   = 2,
  parameter int COMPUTE_CYC = 30
) (
  input  logic                   clk,
  input  logic                   rst,
  sa_load_compute_ctrl_if.slave  bus
);
  localparam int IDX_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_MAX = (FLUSH_CYC > COMPUTE_CYC) ? FLUSH_CYC : COMPUTE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int WORD_W  = DATA_W * LANES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   row, row_n;
  logic [CNT_W-1:0]   cnt, cnt_n;

  logic               ld_ready_q, ld_ready_n;
  logic               en_q, en_n;
  logic               rf_en_q, rf_en_n;
  logic               write_q, write_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [WORD_W-1:0]  din_q, din_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic               hs;
  logic               kill;

  // A row-word transfers only when the registered ready is up (LOAD only).
  assign hs = bus.ld_valid & ld_ready_q;

`ifdef SA_CTRL_ABORT_EN
  assign kill = bus.abort & ((state == S_LOAD) | (state == S_FLUSH) | (state == S_COMPUTE));
`else
  assign kill = 1'b0;
`endif

  // Next-state, counters and next values of all registered outputs.
  always_comb begin
    state_n    = state;
    row_n      = row;
    cnt_n      = cnt;
    idx_n      = idx_q;
    din_n      = din_q;
    ld_ready_n = 1'b0;
    en_n       = 1'b0;
    rf_en_n    = 1'b0;
    write_n    = 1'b0;
    busy_n     = 1'b0;
    done_n     = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_LOAD;
          row_n   = '0;
        end
      end
      S_LOAD: begin
        // A bubble keeps idx/din, so the array just rewrites the same row.
        if (hs) begin
          idx_n = row;
          din_n = bus.ld_data;
          if (row == IDX_W'(ROWS - 1)) begin
            state_n = S_FLUSH;
            row_n   = '0;
            cnt_n   = '0;
          end else begin
            row_n = row + IDX_W'(1);
          end
        end
      end
      S_FLUSH: begin
        if (cnt == CNT_W'(FLUSH_CYC - 1)) begin
          state_n = S_COMPUTE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_COMPUTE: begin
        if (cnt == CNT_W'(COMPUTE_CYC - 1)) begin
          state_n = S_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Abort wins over any handshake; the array side is parked at zero.
    if (kill) begin
      state_n = S_IDLE;
      row_n   = '0;
      cnt_n   = '0;
      idx_n   = '0;
      din_n   = '0;
    end

    // WRITE must stay high from the first load cycle to the end of FLUSH,
    // otherwise the array would start multiplying on a partial RF.
    case (state_n)
      S_LOAD: begin
        ld_ready_n = 1'b1;
        en_n       = 1'b1;
        rf_en_n    = 1'b1;
        write_n    = 1'b1;
        busy_n     = 1'b1;
      end
      S_FLUSH: begin
        en_n    = 1'b1;
        rf_en_n = 1'b1;
        write_n = 1'b1;
        busy_n  = 1'b1;
      end
      S_COMPUTE: begin
        en_n    = 1'b1;
        rf_en_n = 1'b1;
        busy_n  = 1'b1;
      end
      S_DONE: begin
        done_n = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State, counters and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      row        <= '0;
      cnt        <= '0;
      ld_ready_q <= 1'b0;
      en_q       <= 1'b0;
      rf_en_q    <= 1'b0;
      write_q    <= 1'b0;
      idx_q      <= '0;
      din_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_n;
      row        <= row_n;
      cnt        <= cnt_n;
      ld_ready_q <= ld_ready_n;
      en_q       <= en_n;
      rf_en_q    <= rf_en_n;
      write_q    <= write_n;
      idx_q      <= idx_n;
      din_q      <= din_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
    end
  end

  assign bus.ld_ready = ld_ready_q;
  assign bus.sa_en    = en_q;
  assign bus.sa_rf_en = rf_en_q;
  assign bus.sa_write = write_q;
  assign bus.sa_idx   = idx_q;
  assign bus.sa_din   = din_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_sa_load_compute_ctrl.sv
// Directed bench for sa_load_compute_ctrl at default parameters
// (8 rows, FLUSH_CYC=2, COMPUTE_CYC=30). Define SA_CTRL_ABORT_EN to add the abort scenario.
module tb_sa_load_compute_ctrl;
  localparam int DATA_W = 16;
  localparam int LANES  = 16;
  localparam int ROWS   = 8;
  localparam int WORD_W = DATA_W * LANES;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [2:0]        exp_idx;
  logic [WORD_W-1:0] exp_din;

  sa_load_compute_ctrl_if #(.DATA_W(DATA_W), .LANES(LANES), .ROWS(ROWS)) bus ();

  sa_load_compute_ctrl #(
    .DATA_W(DATA_W), .LANES(LANES), .ROWS(ROWS), .FLUSH_CYC(2), .COMPUTE_CYC(30)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WORD_W-1:0] row_word(input int v);
    logic [WORD_W-1:0] w;
    for (int k = 0; k < LANES; k++) w[k*DATA_W +: DATA_W] = v[DATA_W-1:0];
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.ld_ready, bus.sa_en, bus.sa_rf_en, bus.sa_write, bus.busy, bus.done} !== 6'b0 ||
        bus.sa_idx !== 3'd0 || bus.sa_din !== '0) begin
      failures++;
      $display("FAIL reset_init ctrl=%b idx=%0d din=%h exp all zero",
               {bus.ld_ready, bus.sa_en, bus.sa_rf_en, bus.sa_write, bus.busy, bus.done},
               bus.sa_idx, bus.sa_din);
    end
    rst = 1'b0;
    // Start a job and get it into COMPUTE (edge 20).
    bus.start = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_data = row_word(3);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.sa_en, bus.sa_write} !== 3'b110) begin
      failures++;
      $display("FAIL reset_precompute busy/en/write=%b exp 110", {bus.busy, bus.sa_en, bus.sa_write});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.ld_ready, bus.sa_en, bus.sa_rf_en, bus.sa_write, bus.busy, bus.done} !== 6'b0 ||
        bus.sa_idx !== 3'd0 || bus.sa_din !== '0) begin
      failures++;
      $display("FAIL reset_async ctrl=%b idx=%0d din=%h exp all zero",
               {bus.ld_ready, bus.sa_en, bus.sa_rf_en, bus.sa_write, bus.busy, bus.done},
               bus.sa_idx, bus.sa_din);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.ld_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_nodone cyc=%0d done=%b busy=%b exp 0 0", i, bus.done, bus.busy);
      end
    end
    exp_idx = 3'd0;
    exp_din = '0;
  endtask

  // Runs one job with valid held high except for gap_len edges after row gap_row.
  // Optional START re-pulses land in LOAD (edge 3), COMPUTE (edge 20) and DONE.
  task automatic run_job(input string name, input int gap_row, input int gap_len,
                         input int exp_done_edge, input bit pulses);
    int rows;
    int gap;
    int last_hs;
    int ndone;
    bit hs;
    logic exp_ready, exp_write, exp_en, exp_done;
    rows = 0; gap = 0; last_hs = -100; ndone = 0;
    bus.start = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_data = row_word(1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if ({bus.ld_ready, bus.sa_en, bus.sa_rf_en, bus.sa_write, bus.busy, bus.done} !== 6'b111110) begin
      failures++;
      $display("FAIL %s_e0 ctrl=%b exp 111110", name,
               {bus.ld_ready, bus.sa_en, bus.sa_rf_en, bus.sa_write, bus.busy, bus.done});
    end
    for (int e = 1; e <= exp_done_edge + 1; e++) begin
      if (rows == gap_row + 1 && gap < gap_len) begin
        bus.ld_valid = 1'b0;
        gap++;
      end else begin
        bus.ld_valid = 1'b1;
      end
      bus.ld_data = row_word(rows + 1);
      bus.start = pulses && (e == 3 || e == 20 || e == exp_done_edge + 1);
      hs = bus.ld_valid && rows < ROWS;
      @(posedge clk); #1;
      if (hs) begin
        exp_idx = rows[2:0];
        exp_din = row_word(rows + 1);
        rows++;
        last_hs = e;
      end
      exp_ready = (rows < ROWS);
      exp_write = (rows < ROWS) || (e <= last_hs + 1);
      exp_en    = (e < exp_done_edge);
      exp_done  = (e == exp_done_edge);
      if (bus.done === 1'b1) ndone++;
      checks++;
      if (bus.ld_ready !== exp_ready) begin
        failures++;
        $display("FAIL %s_ready e=%0d got %b exp %b", name, e, bus.ld_ready, exp_ready);
      end
      checks++;
      if (bus.sa_write !== exp_write) begin
        failures++;
        $display("FAIL %s_write e=%0d got %b exp %b", name, e, bus.sa_write, exp_write);
      end
      checks++;
      if (bus.sa_en !== exp_en || bus.sa_rf_en !== exp_en || bus.busy !== exp_en) begin
        failures++;
        $display("FAIL %s_en e=%0d en=%b rf_en=%b busy=%b exp %b", name, e,
                 bus.sa_en, bus.sa_rf_en, bus.busy, exp_en);
      end
      checks++;
      if (bus.done !== exp_done) begin
        failures++;
        $display("FAIL %s_done e=%0d got %b exp %b", name, e, bus.done, exp_done);
      end
      checks++;
      if (bus.sa_idx !== exp_idx || bus.sa_din !== exp_din) begin
        failures++;
        $display("FAIL %s_data e=%0d idx=%0d din=%h exp idx=%0d din=%h", name, e,
                 bus.sa_idx, bus.sa_din, exp_idx, exp_din);
      end
    end
    checks++;
    if (ndone != 1) begin
      failures++;
      $display("FAIL %s_donecount got %0d exp 1", name, ndone);
    end
  endtask

  task automatic test_smoke();
    run_job("smoke", -1, 0, 40, 1'b0);
  endtask

  task automatic test_idle_valid();
    bus.start = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data = row_word(16'h55);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.ld_ready !== 1'b0 || bus.busy !== 1'b0 || bus.sa_write !== 1'b0 ||
          bus.sa_idx !== exp_idx || bus.sa_din !== exp_din) begin
        failures++;
        $display("FAIL idle_valid cyc=%0d ready=%b busy=%b write=%b idx=%0d exp 0 0 0 idx=%0d",
                 i, bus.ld_ready, bus.busy, bus.sa_write, bus.sa_idx, exp_idx);
      end
    end
  endtask

  task automatic test_bubbles();
    run_job("bubbles", 4, 3, 43, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_job("startign", -1, 0, 40, 1'b1);
    run_job("restart", -1, 0, 40, 1'b0);
  endtask

`ifdef SA_CTRL_ABORT_EN
  task automatic test_abort();
    int nd;
    bus.abort = 1'b0;
    bus.start = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_data = row_word(2);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    checks++;
    if ({bus.ld_ready, bus.sa_en, bus.sa_rf_en, bus.sa_write, bus.busy, bus.done} !== 6'b0 ||
        bus.sa_idx !== 3'd0 || bus.sa_din !== '0) begin
      failures++;
      $display("FAIL abort_outputs ctrl=%b idx=%0d exp all zero",
               {bus.ld_ready, bus.sa_en, bus.sa_rf_en, bus.sa_write, bus.busy, bus.done}, bus.sa_idx);
    end
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) nd++;
    end
    checks++;
    if (nd != 0) begin
      failures++;
      $display("FAIL abort_nodone got %0d pulses exp 0", nd);
    end
    // START is still taken in IDLE while ABORT is high.
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_restart busy=%b ready=%b exp 1 1", bus.busy, bus.ld_ready);
    end
    nd = 0;
    for (int e = 1; e <= 41; e++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        nd++;
        checks++;
        if (e != 40) begin
          failures++;
          $display("FAIL abort_restart_done edge got %0d exp 40", e);
        end
      end
    end
    checks++;
    if (nd != 1) begin
      failures++;
      $display("FAIL abort_restart_count got %0d exp 1", nd);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    exp_idx = 3'd0;
    exp_din = '0;
`ifdef SA_CTRL_ABORT_EN
    bus.abort = 1'b0;
`endif
    test_reset();
    test_smoke();
    test_idle_valid();
    test_bubbles();
    test_back_to_back();
`ifdef SA_CTRL_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
